// File: rtl/reorder_pkg.sv
// Shared types and helpers for the reorder-tag scheduler: per-tag state
// encoding, packet_status codes and the modulo tag increment.
package reorder_pkg;

    localparam int DEFAULT_TAG_WIDTH   = 6;
    localparam int DEFAULT_BUFFER_SIZE = 50;

    // Lifecycle of one reorder tag: granted -> verdict -> retired back to FREE.
    typedef enum logic [1:0] {
        FREE = 2'b00,
        WAIT = 2'b01,
        ACC  = 2'b10,
        REJ  = 2'b11
    } tag_state_t;

    localparam logic [1:0] STATUS_PENDING = 2'b00;
    localparam logic [1:0] STATUS_REJECT  = 2'b01;
    localparam logic [1:0] STATUS_ACCEPT  = 2'b11;

    // Next tag in the circular tag space 0..size-1.
    function automatic int wrap_inc(input int tag, input int size);
        return (tag >= size - 1) ? 0 : tag + 1;
    endfunction

endpackage

// File: rtl/reorder_tag_scheduler_tag_state_table.sv
// Register file holding the 2-bit state of every reorder tag, with separate
// write ports for allocation, verdict and retire and three read ports.
// Reads of indices beyond the tag space return FREE.
module tag_state_table
    import reorder_pkg::*;
#(
    parameter int TAG_WIDTH = DEFAULT_TAG_WIDTH,
    parameter int SIZE      = DEFAULT_BUFFER_SIZE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alloc_we_i,
    input  logic [TAG_WIDTH-1:0] alloc_idx_i,
    input  logic                 verdict_we_i,
    input  logic [TAG_WIDTH-1:0] verdict_idx_i,
    input  tag_state_t           verdict_state_i,
    input  logic                 retire_we_i,
    input  logic [TAG_WIDTH-1:0] retire_idx_i,
    input  logic [TAG_WIDTH-1:0] status_idx_i,
    output tag_state_t           status_state_o,
    input  logic [TAG_WIDTH-1:0] head_idx_i,
    output tag_state_t           head_state_o,
    input  logic [TAG_WIDTH-1:0] check_idx_i,
    output tag_state_t           check_state_o
);

    localparam logic [TAG_WIDTH-1:0] LastIdx = TAG_WIDTH'(SIZE - 1);

    tag_state_t stateTable_q [SIZE];
    tag_state_t stateTable_d [SIZE];

    // The top only raises each write enable for a tag in the state that port
    // expects, so the three writes never target the same entry.
    always_comb begin
        stateTable_d = stateTable_q;
        if (alloc_we_i) begin
            stateTable_d[alloc_idx_i] = WAIT;
        end
        if (verdict_we_i) begin
            stateTable_d[verdict_idx_i] = verdict_state_i;
        end
        if (retire_we_i) begin
            stateTable_d[retire_idx_i] = FREE;
        end
    end

    // State storage; reset returns every tag to FREE.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < SIZE; i++) begin
                stateTable_q[i] <= FREE;
            end
        end else begin
            stateTable_q <= stateTable_d;
        end
    end

    assign status_state_o = (status_idx_i <= LastIdx) ? stateTable_q[status_idx_i] : FREE;
    assign head_state_o   = (head_idx_i   <= LastIdx) ? stateTable_q[head_idx_i]   : FREE;
    assign check_state_o  = (check_idx_i  <= LastIdx) ? stateTable_q[check_idx_i]  : FREE;

endmodule

// File: rtl/reorder_tag_scheduler.sv
// Reorder-tag scheduler: hands out tags in arrival order, records filter
// verdicts per tag, reports the verdict of the tag being drained and takes
// tags back in order on retire. Protocol violations latch err_sticky.
module reorder_tag_scheduler
    import reorder_pkg::*;
#(
    parameter int TAG_WIDTH            = DEFAULT_TAG_WIDTH,
    parameter int CIRCULAR_BUFFER_SIZE = DEFAULT_BUFFER_SIZE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alloc_valid,
    output logic                 alloc_ready,
    output logic [TAG_WIDTH-1:0] alloc_tag,
    input  logic                 verdict_valid,
    input  logic [TAG_WIDTH-1:0] verdict_tag,
    input  logic                 verdict_accept,
    input  logic [TAG_WIDTH-1:0] status_tag,
    output logic [1:0]           packet_status,
    input  logic                 retire_valid,
    input  logic [TAG_WIDTH-1:0] retire_tag,
    output logic [TAG_WIDTH:0]   occupancy,
    output logic                 err_sticky
);

    localparam logic [TAG_WIDTH:0] FullCount = (TAG_WIDTH + 1)'(CIRCULAR_BUFFER_SIZE);
    localparam logic [TAG_WIDTH:0] OneCount  = (TAG_WIDTH + 1)'(1);

    logic [TAG_WIDTH-1:0] allocPtr_q, allocPtr_d;
    logic [TAG_WIDTH-1:0] headPtr_q, headPtr_d;
    logic [TAG_WIDTH:0]   occupancy_q, occupancy_d;
    logic                 errSticky_q, errSticky_d;

    logic       grant;
    logic       verdictLegal;
    logic       retireLegal;
    tag_state_t verdictState;
    tag_state_t statusState;
    tag_state_t headState;
    tag_state_t checkState;

    // Readiness comes only from registered occupancy, so a retire in the same
    // cycle never opens the grant path combinationally.
    assign alloc_ready  = (occupancy_q < FullCount);
    assign alloc_tag    = allocPtr_q;
    assign occupancy    = occupancy_q;
    assign err_sticky   = errSticky_q;

    assign grant        = alloc_valid && alloc_ready;
    assign verdictState = verdict_accept ? ACC : REJ;
    assign verdictLegal = verdict_valid && (checkState == WAIT);
    assign retireLegal  = retire_valid && (retire_tag == headPtr_q)
                          && ((headState == ACC) || (headState == REJ));

    tag_state_table #(
        .TAG_WIDTH (TAG_WIDTH),
        .SIZE      (CIRCULAR_BUFFER_SIZE)
    ) u_table (
        .clk             (clk),
        .rst             (rst),
        .alloc_we_i      (grant),
        .alloc_idx_i     (allocPtr_q),
        .verdict_we_i    (verdictLegal),
        .verdict_idx_i   (verdict_tag),
        .verdict_state_i (verdictState),
        .retire_we_i     (retireLegal),
        .retire_idx_i    (headPtr_q),
        .status_idx_i    (status_tag),
        .status_state_o  (statusState),
        .head_idx_i      (headPtr_q),
        .head_state_o    (headState),
        .check_idx_i     (verdict_tag),
        .check_state_o   (checkState)
    );

    // Maps the drained tag's state onto the buffer's status code.
    always_comb begin
        case (statusState)
            ACC:     packet_status = STATUS_ACCEPT;
            REJ:     packet_status = STATUS_REJECT;
            default: packet_status = STATUS_PENDING;
        endcase
    end

    // Next-state for pointers, occupancy and the sticky protocol error.
    always_comb begin
        allocPtr_d  = allocPtr_q;
        headPtr_d   = headPtr_q;
        occupancy_d = occupancy_q;
        errSticky_d = errSticky_q;
        if (grant) begin
            allocPtr_d = TAG_WIDTH'(wrap_inc(int'(allocPtr_q), CIRCULAR_BUFFER_SIZE));
        end
        if (retireLegal) begin
            headPtr_d = TAG_WIDTH'(wrap_inc(int'(headPtr_q), CIRCULAR_BUFFER_SIZE));
        end
        case ({grant, retireLegal})
            2'b10:   occupancy_d = occupancy_q + OneCount;
            2'b01:   occupancy_d = occupancy_q - OneCount;
            default: occupancy_d = occupancy_q;
        endcase
        if ((verdict_valid && !verdictLegal) || (retire_valid && !retireLegal)) begin
            errSticky_d = 1'b1;
        end
    end

    // Control registers; reset discards everything, including verdicts in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            allocPtr_q  <= '0;
            headPtr_q   <= '0;
            occupancy_q <= '0;
            errSticky_q <= 1'b0;
        end else begin
            allocPtr_q  <= allocPtr_d;
            headPtr_q   <= headPtr_d;
            occupancy_q <= occupancy_d;
            errSticky_q <= errSticky_d;
        end
    end

endmodule

// File: tb/tb_reorder_tag_scheduler.sv
// Scoreboard bench for reorder_tag_scheduler: directed scenarios followed by
// random traffic, checked against a queue-based model of the tag space.
module tb_reorder_tag_scheduler;

    localparam int TW   = 6;
    localparam int SIZE = 50;

    logic          clk;
    logic          rst;
    logic          alloc_valid;
    logic          alloc_ready;
    logic [TW-1:0] alloc_tag;
    logic          verdict_valid;
    logic [TW-1:0] verdict_tag;
    logic          verdict_accept;
    logic [TW-1:0] status_tag;
    logic [1:0]    packet_status;
    logic          retire_valid;
    logic [TW-1:0] retire_tag;
    logic [TW:0]   occupancy;
    logic          err_sticky;

    reorder_tag_scheduler #(
        .TAG_WIDTH            (TW),
        .CIRCULAR_BUFFER_SIZE (SIZE)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .alloc_valid    (alloc_valid),
        .alloc_ready    (alloc_ready),
        .alloc_tag      (alloc_tag),
        .verdict_valid  (verdict_valid),
        .verdict_tag    (verdict_tag),
        .verdict_accept (verdict_accept),
        .status_tag     (status_tag),
        .packet_status  (packet_status),
        .retire_valid   (retire_valid),
        .retire_tag     (retire_tag),
        .occupancy      (occupancy),
        .err_sticky     (err_sticky)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic          ready;
        logic [TW-1:0] tag;
        logic [TW:0]   occ;
        logic          err;
        logic [1:0]    status;
    } exp_t;

    exp_t expQ[$];
    int   checkCount = 0;
    int   failCount  = 0;

    // Model: outstanding tags in grant order, verdict per tag (0 none, 1 acc, 2 rej).
    int outQ[$];
    int verdictOf[SIZE];
    bit liveOf[SIZE];
    int nextTag;
    bit errModel;
    bit modelValid = 1'b0;

    function automatic logic [1:0] expectedStatus(input int t);
        if (t >= SIZE) return 2'b00;
        if (!liveOf[t]) return 2'b00;
        if (verdictOf[t] == 1) return 2'b11;
        if (verdictOf[t] == 2) return 2'b01;
        return 2'b00;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        outQ.delete();
        for (int i = 0; i < SIZE; i++) begin
            verdictOf[i] = 0;
            liveOf[i]    = 1'b0;
        end
        nextTag  = 0;
        errModel = 1'b0;
    endtask

    // Drives one cycle of inputs, queues the outputs the DUT must show during
    // that cycle, then advances the model by the effect of those inputs.
    task automatic applyStimulus(input bit rstN, input bit av, input bit vv, input int vtag,
                                 input bit vacc, input int stag, input bit rv, input int rtag);
        exp_t e;
        bit   vLegal;
        bit   rLegal;
        bit   grant;
        rst            = rstN;
        alloc_valid    = av;
        verdict_valid  = vv;
        verdict_tag    = TW'(vtag);
        verdict_accept = vacc;
        status_tag     = TW'(stag);
        retire_valid   = rv;
        retire_tag     = TW'(rtag);
        if (modelValid) begin
            e.ready  = (outQ.size() < SIZE);
            e.tag    = TW'(nextTag);
            e.occ    = (TW + 1)'(outQ.size());
            e.err    = errModel;
            e.status = expectedStatus(stag);
            expQ.push_back(e);
        end
        if (!rstN) begin
            modelReset();
            modelValid = 1'b1;
        end else begin
            vLegal = 1'b0;
            if (vv && vtag < SIZE) begin
                if (liveOf[vtag] && verdictOf[vtag] == 0) vLegal = 1'b1;
            end
            rLegal = 1'b0;
            if (rv && outQ.size() > 0) begin
                if (rtag == outQ[0] && verdictOf[outQ[0]] != 0) rLegal = 1'b1;
            end
            grant = av && (outQ.size() < SIZE);
            if ((vv && !vLegal) || (rv && !rLegal)) errModel = 1'b1;
            if (vLegal) verdictOf[vtag] = vacc ? 1 : 2;
            if (rLegal) begin
                liveOf[outQ[0]]    = 1'b0;
                verdictOf[outQ[0]] = 0;
                void'(outQ.pop_front());
            end
            if (grant) begin
                outQ.push_back(nextTag);
                liveOf[nextTag]    = 1'b1;
                verdictOf[nextTag] = 0;
                nextTag            = (nextTag + 1) % SIZE;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 0);
    endtask

    task automatic idle(input int stag);
        applyStimulus(1'b1, 1'b0, 1'b0, 0, 1'b0, stag, 1'b0, 0);
    endtask

    task automatic grantOne(input int stag);
        applyStimulus(1'b1, 1'b1, 1'b0, 0, 1'b0, stag, 1'b0, 0);
    endtask

    task automatic verdict(input int vtag, input bit acc, input int stag);
        applyStimulus(1'b1, 1'b0, 1'b1, vtag, acc, stag, 1'b0, 0);
    endtask

    task automatic retire(input int rtag, input int stag);
        applyStimulus(1'b1, 1'b0, 1'b0, 0, 1'b0, stag, 1'b1, rtag);
    endtask

    // Monitor: compares the DUT against the oldest queued expectation each cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("alloc_ready", 32'(alloc_ready), 32'(e.ready));
                checkOutput("alloc_tag", 32'(alloc_tag), 32'(e.tag));
                checkOutput("occupancy", 32'(occupancy), 32'(e.occ));
                checkOutput("err_sticky", 32'(err_sticky), 32'(e.err));
                checkOutput("packet_status", 32'(packet_status), 32'(e.status));
            end
        end
    end

    // Directed scenarios, then randomized traffic steered by the model.
    initial begin
        bit av, vv, vacc, rv, rstN;
        int vtag, stag, rtag;
        rst = 1'b0; alloc_valid = 1'b0; verdict_valid = 1'b0; verdict_tag = '0;
        verdict_accept = 1'b0; status_tag = '0; retire_valid = 1'b0; retire_tag = '0;
        modelReset();

        doReset();
        idle(0);
        repeat (3) grantOne(0);
        idle(0);
        verdict(1, 1'b0, 1);
        verdict(0, 1'b1, 0);
        idle(0);
        idle(1);
        retire(0, 0);
        retire(1, 1);
        idle(2);
        verdict(2, 1'b1, 2);
        retire(2, 2);
        idle(2);

        doReset();
        repeat (SIZE) grantOne(0);
        grantOne(0);
        applyStimulus(1'b1, 1'b1, 1'b1, 0, 1'b1, 0, 1'b0, 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 0, 1'b0, 0, 1'b1, 0);
        grantOne(0);
        grantOne(1);
        idle(0);

        doReset();
        repeat (3) grantOne(0);
        verdict(0, 1'b0, 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 0, 1'b0, 0, 1'b1, 0);
        idle(0);
        idle(3);

        doReset();
        repeat (2) grantOne(0);
        verdict(5, 1'b1, 5);
        idle(5);
        doReset();
        repeat (2) grantOne(0);
        verdict(1, 1'b1, 1);
        retire(1, 1);
        idle(1);
        doReset();
        repeat (2) grantOne(0);
        retire(0, 0);
        idle(0);
        doReset();
        grantOne(0);
        verdict(60, 1'b1, 60);
        idle(55);

        doReset();
        repeat (10) grantOne(0);
        verdict(3, 1'b1, 3);
        verdict(4, 1'b0, 4);
        verdict(20, 1'b1, 3);
        doReset();
        idle(3);
        idle(4);
        idle(0);

        for (int cyc = 0; cyc < 3000; cyc++) begin
            rstN = ($urandom_range(0, 299) != 0);
            av   = ($urandom_range(0, 3) != 0);
            vv = 1'b0; vtag = 0; vacc = $urandom_range(0, 1) != 0;
            if (outQ.size() > 0 && $urandom_range(0, 9) < 6) begin
                vv = 1'b1;
                vtag = outQ[$urandom_range(0, outQ.size() - 1)];
            end else if ($urandom_range(0, 39) == 0) begin
                vv = 1'b1;
                vtag = $urandom_range(0, 63);
            end
            rv = 1'b0; rtag = 0;
            if (outQ.size() > 0 && $urandom_range(0, 9) < 5) begin
                if (verdictOf[outQ[0]] != 0) begin
                    rv = 1'b1;
                    rtag = outQ[0];
                end
            end else if ($urandom_range(0, 59) == 0) begin
                rv = 1'b1;
                rtag = $urandom_range(0, 63);
            end
            if (outQ.size() > 0 && $urandom_range(0, 1) == 0) stag = outQ[0];
            else stag = $urandom_range(0, 63);
            applyStimulus(rstN, av, vv, vtag, vacc, stag, rv, rtag);
        end
        idle(0);

        @(negedge clk);
        #1;
        checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
